// File: rtl/sw_word_loader_pkg.sv
// Shared constants for the switch word loader: byte width, lane count,
// FSM state encodings and a lane-insert helper.
package sw_word_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = BYTE_W * LANES;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  function automatic logic [WORD_W-1:0] put_lane(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        lane,
    input logic [BYTE_W-1:0] data
  );
    logic [WORD_W-1:0] result;
    result = word;
    result[lane*BYTE_W +: BYTE_W] = data;
    return result;
  endfunction

endpackage

// File: rtl/sw_word_loader_if.sv
// Consumer-side handshake of the word loader: the assembled word, its
// valid flag, the next lane index and the consumer's ready.
interface sw_word_loader_if;
  import sw_word_loader_pkg::*;

  logic [WORD_W-1:0] Word;
  logic              Valid;
  logic [1:0]        Idx;
  logic              Ready;

  modport master (output Word, output Valid, output Idx, input Ready);
  modport slave  (input Word, input Valid, input Idx, output Ready);

endinterface

// File: rtl/sw_word_loader_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, counter-based debouncer and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic BTN,
  output logic pulse
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // The level flips on the DEB_CYCLES-th consecutive differing sample, and the
  // pulse is raised on that same edge so it is high during the following cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_a <= BTN;
      sync_b <= sync_a;
      pulse  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_b;
        pulse <= sync_b;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_word_loader.sv
// Assembles a 32-bit operand from four debounced switch loads and holds it
// for a ready/valid consumer.
module sw_word_loader
  import sw_word_loader_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [BYTE_W-1:0] SW,
  input  logic              BTN,
  input  logic              CLR,
  sw_word_loader_if.master  bus
);

  logic   load;
  state_t state;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .Clk   (Clk),
    .Rst   (Rst),
    .BTN   (BTN),
    .pulse (load)
  );

  // Reset beats CLR, and CLR beats any load pulse or Ready in the same cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= COLLECT;
      bus.Word  <= '0;
      bus.Valid <= 1'b0;
      bus.Idx   <= 2'd0;
    end else if (CLR) begin
      state     <= COLLECT;
      bus.Word  <= '0;
      bus.Valid <= 1'b0;
      bus.Idx   <= 2'd0;
    end else begin
      case (state)
        COLLECT: begin
          if (load) begin
            bus.Word <= put_lane(bus.Word, bus.Idx, SW);
            bus.Idx  <= bus.Idx + 2'd1;
            if (bus.Idx == 2'd3) begin
              state     <= FULL;
              bus.Valid <= 1'b1;
            end
          end
        end
        FULL: begin
          if (bus.Ready) begin
            state     <= COLLECT;
            bus.Valid <= 1'b0;
          end
        end
        default: begin
          state     <= COLLECT;
          bus.Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sw_word_loader.sv
// Directed self-checking bench for sw_word_loader with a short debounce window.
module tb_sw_word_loader;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic       btn;
  logic       clr;
  int         checks;
  int         errors;

  sw_word_loader_if bus();

  sw_word_loader #(
    .DEB_CYCLES(4)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .SW  (sw),
    .BTN (btn),
    .CLR (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clean press: long enough high and low to pass the filter both ways.
  task automatic applyStimulus(input logic [7:0] val);
    sw  = val;
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(10);
  endtask

  task automatic check_state(input string tag, input logic [31:0] w, input logic v, input logic [1:0] i);
    checkOutput({tag, "_word"}, bus.Word, w);
    checkOutput({tag, "_valid"}, {31'd0, bus.Valid}, {31'd0, v});
    checkOutput({tag, "_idx"}, {30'd0, bus.Idx}, {30'd0, i});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    btn       = 1'b1;
    clr       = 1'b0;
    sw        = 8'h00;
    bus.Ready = 1'b0;
    tick(2);
    check_state("reset", 32'h0, 1'b0, 2'd0);

    // Button already held at reset release yields exactly one load.
    sw  = 8'hC3;
    rst = 1'b1;
    tick(12);
    check_state("held_at_reset", 32'h0000_00C3, 1'b0, 2'd1);
    btn = 1'b0;
    tick(10);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_state("clr_collect", 32'h0, 1'b0, 2'd0);

    applyStimulus(8'h78);
    checkOutput("fill_idx1", {30'd0, bus.Idx}, 32'd1);
    applyStimulus(8'h56);
    checkOutput("fill_idx2", {30'd0, bus.Idx}, 32'd2);
    applyStimulus(8'h34);
    checkOutput("fill_idx3", {30'd0, bus.Idx}, 32'd3);
    applyStimulus(8'h12);
    check_state("fill_full", 32'h1234_5678, 1'b1, 2'd0);

    applyStimulus(8'hFF);
    applyStimulus(8'hFF);
    check_state("full_hold", 32'h1234_5678, 1'b1, 2'd0);

    bus.Ready = 1'b1;
    tick(1);
    bus.Ready = 1'b0;
    check_state("drain", 32'h1234_5678, 1'b0, 2'd0);

    // Bouncing input: runs of two samples never reach the 4-sample window.
    sw = 8'h9A;
    for (int k = 0; k < 6; k++) begin
      btn = ~btn;
      tick(2);
    end
    btn = 1'b0;
    tick(8);
    check_state("bounce", 32'h1234_5678, 1'b0, 2'd0);
    btn = 1'b1;
    tick(12);
    check_state("bounce_settle", 32'h1234_569A, 1'b0, 2'd1);
    btn = 1'b0;
    tick(10);

    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    check_state("abort_pre", 32'h0000_BBAA, 1'b0, 2'd2);
    // The load pulse is high in the cycle after the 6th edge following the press.
    sw  = 8'hCC;
    btn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_state("abort", 32'h0, 1'b0, 2'd0);
    tick(4);
    check_state("abort_after", 32'h0, 1'b0, 2'd0);
    btn = 1'b0;
    tick(10);

    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    check_state("mid_pre", 32'h0033_2211, 1'b0, 2'd3);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check_state("mid_reset", 32'h0, 1'b0, 2'd0);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    check_state("refill", 32'h7766_5544, 1'b1, 2'd0);
    bus.Ready = 1'b1;
    tick(1);
    bus.Ready = 1'b0;
    checkOutput("refill_drain", {31'd0, bus.Valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_word_loader.md
SW_WORD_LOADER -- requirements
Module: sw_word_loader

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, the number of consecutive stable samples needed to accept a button level change (minimum 2).
REQ-002 SHALL have port Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port Rst  input  1  reset: synchronous, active-low.
REQ-004 SHALL have port SW  input  8  byte value to load from the switches; sampled only on a load pulse.
REQ-005 SHALL have port BTN  input  1  raw, asynchronous, bouncing load pushbutton; active-high.
REQ-006 SHALL have port CLR  input  1  synchronous abort; active-high; Clk-domain.
REQ-007 SHALL have port Ready  input  1  consumer accepts Word when high with Valid.
REQ-008 SHALL have port Word  output  32  assembled operand word.
REQ-009 SHALL have port Valid  output  1  Word is complete and held for the consumer.
REQ-010 SHALL have port Idx  output  2  index of the next byte lane to be written.

Function
REQ-011 SHALL pass BTN through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep a debounced level that changes only after DEB_CYCLES consecutive synchronized samples differ from it.
- Any matching sample clears the counter.
REQ-013 SHALL generate a one-cycle load pulse on the cycle after the debounced level rises 0->1.
- A debounced fall generates no pulse.
REQ-014 SHALL implement a two-state FSM:
- COLLECT: accepting bytes.
- FULL: Valid=1, waiting for Ready.
REQ-015 In COLLECT, a load pulse SHALL write SW into the Word lane selected by Idx, with the result visible on the next cycle.
- Lane mapping: Idx=0 -> Word[7:0] ... Idx=3 -> Word[31:24].
- The same pulse increments Idx modulo 4.
REQ-016 A load pulse with Idx=3 SHALL move the FSM to FULL.
- Valid=1 and Idx=0 on the next cycle.
REQ-017 In FULL, load pulses SHALL be ignored.
- Word, Idx and state are unchanged.
REQ-018 In FULL with Ready=1, the FSM SHALL return to COLLECT on the next cycle.
- Valid=0 on that cycle.
- Word keeps its value until its lanes are overwritten.
REQ-019 Ready SHALL be ignored while Valid=0, including the cycle of the fourth load pulse.
REQ-020 CLR=1 SHALL take effect on the next cycle in either state: Word=0, Idx=0, Valid=0, state COLLECT.
REQ-021 CLR SHALL take priority over a simultaneous load pulse or Ready.
- The debouncer is not affected by CLR.
REQ-022 Word, Valid and Idx SHALL be registered outputs with no combinational path from any input.

Reset
REQ-023 When Rst=0 at a rising edge, the block SHALL set Word=0, Valid=0, Idx=0 and state COLLECT.
- Synchronizer flops, debounced level and debounce counter are also cleared.
REQ-024 Rst=0 SHALL override CLR, load pulses and Ready, including during collection or while FULL.
REQ-025 After Rst returns high with BTN already held high, one load pulse SHALL occur once the level passes the debounce filter.

Structure
REQ-026 The FSM state encodings and the byte width (8) SHALL be defined in the shared constants header included by sw_word_loader.
REQ-027 The synchronizer, debouncer and rising-edge pulse SHALL be one sub-module, btn_debounce.
- btn_debounce carries the DEB_CYCLES parameter and the same Clk/Rst.
REQ-028 The debounce counter width SHALL be derived from DEB_CYCLES, with no fixed width.

Verification (bench uses DEB_CYCLES=4)
REQ-029 Reset: Rst=0 for 2 cycles with BTN=1, CLR=0 -> Word=32'h0, Valid=0, Idx=0.
REQ-030 Fill: four clean presses with SW=8'h78, 8'h56, 8'h34, 8'h12 -> Word=32'h12345678, Valid=1, Idx=0; Ready=1 for one cycle -> Valid=0 on the next cycle.
REQ-031 Bounce: BTN toggling every 2 cycles for 12 cycles -> no load pulse and Idx unchanged; then BTN held high -> exactly one load, Idx=1.
REQ-032 Full hold: presses with SW=8'hFF while FULL and Ready=0 -> Word stays 32'h12345678, Idx=0, Valid stays 1.
REQ-033 Abort: after 2 bytes (8'hAA, 8'hBB), CLR=1 in the same cycle as a load pulse -> Word=0, Idx=0, Valid=0; no byte is written.
REQ-034 Reset mid-collection: Rst=0 after 3 bytes -> Word=0, Idx=0; four fresh presses then produce a correct new word.
